// File: rtl/spi_eeprom_responder_pkg.sv
// Shared opcodes, status byte and FSM encoding for the SPI EEPROM responder.
package spi_eeprom_defs;

  localparam logic [7:0] OP_READ     = 8'h03;
  localparam logic [7:0] OP_RDSR     = 8'h05;
  localparam logic [7:0] STATUS_BYTE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_STATUS = 3'd4,
    ST_IGNORE = 3'd5
  } state_t;

endpackage

// File: rtl/spi_eeprom_responder_if.sv
// SPI link plus preload port; master = initiator/bench side, slave = responder side.
interface spi_eeprom_responder_if #(
  parameter int ADDR_W = 7
);
  logic              cs;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;

  modport master (
    output cs, sclk, mosi, load_we, load_addr, load_data,
    input  miso, miso_oe
  );

  modport slave (
    input  cs, sclk, mosi, load_we, load_addr, load_data,
    output miso, miso_oe
  );
endinterface

// File: rtl/spi_eeprom_responder_sync.sv
// Multi-flop synchronizer with registered rise/fall pulses (STAGES+1 clk from pin).
// Chain resets to 0, so a line held low through reset never produces a fall.
module spi_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              w_q;

  assign w_q = r_sync[STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= w_q;
      o_rise <= w_q & ~r_prev;
      o_fall <= ~w_q & r_prev;
    end
  end
endmodule

// File: rtl/spi_eeprom_responder.sv
// Mode-0 SPI EEPROM target: READ (0x03) + address bytes streams mem bytes, RDSR returns 0x00.
// All SPI pins are oversampled by clk (>= 8x sclk); memory survives reset.
module spi_eeprom_responder
  import spi_eeprom_defs::*;
#(
  parameter int MEM_DEPTH   = 128,
  parameter int ADDR_BYTES  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  spi_eeprom_responder_if.slave    bus,
  output logic                     busy,
  output logic [7:0]               rd_count
);
  localparam int ADDR_W    = $clog2(MEM_DEPTH);
  localparam int ADDR_BITS = 8 * ADDR_BYTES;
  localparam int CNT_W     = $clog2(ADDR_BITS);

  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [6:0]              r_cmd;
  logic [ADDR_W-1:0]       r_addr;
  logic [7:0]              r_tx;
  logic                    r_miso;
  logic [7:0]              r_rd_count;
  logic                    r_busy;
  logic [SYNC_STAGES-1:0]  r_mosi_sync;
  logic [7:0]              r_mem [MEM_DEPTH];

  logic                    w_cs_rise, w_cs_fall, w_sclk_rise, w_sclk_fall;
  logic                    w_mosi, w_byte_end, w_addr_end, w_oe;
  logic [7:0]              w_cmd_byte;
  logic [ADDR_W-1:0]       w_addr_shift, w_fetch_addr;
  logic                    w_fetch, w_load_status;
  logic [7:0]              w_fetch_dat;

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk    (clk),
    .reset  (reset),
    .i_d    (bus.cs),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk    (clk),
    .reset  (reset),
    .i_d    (bus.sclk),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) r_mosi_sync <= '0;
    else       r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
  end

  assign w_mosi       = r_mosi_sync[SYNC_STAGES-1];
  assign w_byte_end   = (r_bit_cnt[2:0] == 3'd7);
  assign w_addr_end   = (r_bit_cnt == CNT_W'(ADDR_BITS - 1));
  assign w_cmd_byte   = {r_cmd, w_mosi};
  assign w_addr_shift = {r_addr[ADDR_W-2:0], w_mosi};
  assign w_oe         = (r_state == ST_DATA) || (r_state == ST_STATUS);

  // Write-first: a preload landing on the fetch address in the same clk wins.
  assign w_fetch_dat = (bus.load_we && (bus.load_addr == w_fetch_addr))
                       ? bus.load_data : r_mem[w_fetch_addr];

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_fetch       = 1'b0;
    w_fetch_addr  = r_addr + ADDR_W'(1);
    w_load_status = 1'b0;
    case (r_state)
      ST_IDLE: if (w_cs_fall) w_state_nxt = ST_CMD;
      ST_CMD: begin
        if (w_sclk_rise && w_byte_end) begin
          if (w_cmd_byte == OP_READ) begin
            w_state_nxt = ST_ADDR;
          end else if (w_cmd_byte == OP_RDSR) begin
            w_state_nxt   = ST_STATUS;
            w_load_status = 1'b1;
          end else begin
            w_state_nxt = ST_IGNORE;
          end
        end
      end
      ST_ADDR: begin
        w_fetch_addr = w_addr_shift;
        if (w_sclk_rise && w_addr_end) begin
          w_state_nxt = ST_DATA;
          w_fetch     = 1'b1;
        end
      end
      ST_DATA:   w_fetch       = w_sclk_rise && w_byte_end;
      ST_STATUS: w_load_status = w_sclk_rise && w_byte_end;
      default:   w_state_nxt   = r_state;
    endcase
    if (w_cs_rise) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt  <= '0;
      r_cmd      <= '0;
      r_addr     <= '0;
      r_tx       <= '0;
      r_miso     <= 1'b0;
      r_rd_count <= '0;
      r_busy     <= 1'b0;
    end else begin
      if (w_cs_fall)      r_busy <= 1'b1;
      else if (w_cs_rise) r_busy <= 1'b0;

      if (r_state == ST_IDLE) begin
        r_bit_cnt <= '0;
        r_miso    <= 1'b0;
        if (w_cs_fall) r_rd_count <= '0;
      end else if (w_cs_rise) begin
        r_bit_cnt <= '0;
        r_miso    <= 1'b0;
      end else begin
        if (w_sclk_rise) begin
          r_cmd <= w_cmd_byte[6:0];
          if ((r_state == ST_ADDR) ? w_addr_end : w_byte_end) r_bit_cnt <= '0;
          else                                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          if (r_state == ST_ADDR) r_addr <= w_addr_shift;
          if (r_state == ST_DATA && w_byte_end) begin
            r_addr <= w_fetch_addr;
            if (r_rd_count != 8'hFF) r_rd_count <= r_rd_count + 8'd1;
          end
        end
        if (w_fetch)            r_tx <= w_fetch_dat;
        else if (w_load_status) r_tx <= STATUS_BYTE;
        // Mode 0: the target changes miso on the falling edge, MSB first.
        if (w_sclk_fall && w_oe) begin
          r_miso <= r_tx[7];
          r_tx   <= {r_tx[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.load_we) r_mem[bus.load_addr] <= bus.load_data;
  end

  assign bus.miso    = w_oe & r_miso;
  assign bus.miso_oe = w_oe;
  assign busy        = r_busy;
  assign rd_count    = r_rd_count;
endmodule

// File: tb/tb_spi_eeprom_responder.sv
// Directed bench for spi_eeprom_responder: streaming, wrap, RDSR, unknown opcode, abort, reset, write-first.
module tb_spi_eeprom_responder;
  logic       clk;
  logic       reset;
  logic       busy;
  logic [7:0] rd_count;
  logic [7:0] rx;
  logic       oe_and, oe_or;
  int         total, bad;

  spi_eeprom_responder_if #(.ADDR_W(7)) bus ();

  spi_eeprom_responder #(.MEM_DEPTH(128), .ADDR_BYTES(3), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .rd_count (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One mode-0 byte (or nbits of it); optional preload pulse aligned with the 8th-rise fetch.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, input logic ld_en,
                          input logic [6:0] ld_addr, input logic [7:0] ld_dat,
                          output logic [7:0] rxb);
    rxb = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = tx[7-i];
      wait_clk(8);
      rxb    = {rxb[6:0], bus.miso};
      oe_and = oe_and & bus.miso_oe;
      oe_or  = oe_or | bus.miso_oe;
      bus.sclk = 1'b1;
      if (ld_en && i == 7) begin
        wait_clk(3);
        bus.load_we   = 1'b1;
        bus.load_addr = ld_addr;
        bus.load_data = ld_dat;
        wait_clk(1);
        bus.load_we = 1'b0;
        wait_clk(4);
      end else begin
        wait_clk(8);
      end
      bus.sclk = 1'b0;
    end
  endtask

  task automatic byte_io(input logic [7:0] tx, output logic [7:0] rxb);
    spi_xfer(tx, 8, 1'b0, 7'd0, 8'd0, rxb);
  endtask

  task automatic cs_low();
    bus.cs = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    wait_clk(4);
    bus.cs = 1'b1;
    wait_clk(8);
  endtask

  task automatic read_start(input logic [23:0] a);
    logic [7:0] d;
    byte_io(8'h03, d);
    byte_io(a[23:16], d);
    byte_io(a[15:8], d);
    byte_io(a[7:0], d);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    oe_and = 1'b1;
    oe_or  = 1'b0;
    reset = 1'b1;
    bus.cs = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.load_we = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    wait_clk(3);
    check("rst_miso", bus.miso, 0);
    check("rst_oe", bus.miso_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_rdcnt", rd_count, 0);
    reset = 1'b0;
    wait_clk(6);

    for (int i = 0; i < 128; i++) begin
      bus.load_we   = 1'b1;
      bus.load_addr = 7'(i);
      bus.load_data = 8'(i) ^ 8'h5A;
      wait_clk(1);
    end
    bus.load_we = 1'b0;

    // 100-byte stream from address 0
    cs_low();
    check("busy_cs_low", busy, 1);
    read_start(24'h000000);
    oe_and = 1'b1;
    for (int i = 0; i < 100; i++) begin
      byte_io(8'h00, rx);
      check($sformatf("stream[%0d]", i), rx, 8'(i) ^ 8'h5A);
    end
    check("stream_oe", oe_and, 1);
    check("stream_rdcnt", rd_count, 100);
    cs_high();
    check("busy_cs_high", busy, 0);
    check("idle_oe", bus.miso_oe, 0);

    // Wrap at MEM_DEPTH-1
    cs_low();
    read_start(24'h00007E);
    byte_io(8'h00, rx); check("wrap0", rx, 8'h24);
    byte_io(8'h00, rx); check("wrap1", rx, 8'h25);
    byte_io(8'h00, rx); check("wrap2", rx, 8'h5A);
    byte_io(8'h00, rx); check("wrap3", rx, 8'h5B);
    check("wrap_rdcnt", rd_count, 4);
    cs_high();

    // RDSR
    cs_low();
    byte_io(8'h05, rx);
    oe_and = 1'b1;
    byte_io(8'h00, rx); check("rdsr0", rx, 8'h00);
    byte_io(8'h00, rx); check("rdsr1", rx, 8'h00);
    check("rdsr_oe", oe_and, 1);
    cs_high();

    // Unknown opcode stays silent
    cs_low();
    byte_io(8'h9F, rx);
    oe_or = 1'b0;
    byte_io(8'h00, rx); check("ign_miso", rx, 8'h00);
    byte_io(8'h00, rx);
    check("ign_oe", oe_or, 0);
    cs_high();
    check("ign_oe_after", bus.miso_oe, 0);

    // Abort after 3 bits of the 2nd data byte, then read at 0x10
    cs_low();
    read_start(24'h000000);
    byte_io(8'h00, rx); check("abort_b0", rx, 8'h5A);
    spi_xfer(8'h00, 3, 1'b0, 7'd0, 8'd0, rx);
    cs_high();
    cs_low();
    check("abort_rdcnt_clr", rd_count, 0);
    read_start(24'h000010);
    byte_io(8'h00, rx); check("after_abort", rx, 8'h4A);
    check("after_abort_rdcnt", rd_count, 1);
    cs_high();

    // Reset mid-DATA with cs held low
    cs_low();
    read_start(24'h000020);
    byte_io(8'h00, rx); check("pre_rst", rx, 8'h7A);
    reset = 1'b1;
    wait_clk(1);
    check("mid_rst_oe", bus.miso_oe, 0);
    check("mid_rst_miso", bus.miso, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rdcnt", rd_count, 0);
    reset = 1'b0;
    oe_or = 1'b0;
    byte_io(8'h00, rx); check("post_rst_miso", rx, 8'h00);
    byte_io(8'h00, rx);
    check("post_rst_oe", oe_or, 0);
    check("post_rst_busy", busy, 0);
    cs_high();
    cs_low();
    read_start(24'h000020);
    byte_io(8'h00, rx); check("mem_intact", rx, 8'h7A);
    cs_high();

    // Preload colliding with the fetch of 0x31
    cs_low();
    read_start(24'h000030);
    spi_xfer(8'h00, 8, 1'b1, 7'h31, 8'hC3, rx); check("wf_b0", rx, 8'h6A);
    byte_io(8'h00, rx); check("wf_b1", rx, 8'hC3);
    byte_io(8'h00, rx); check("wf_b2", rx, 8'h68);
    check("wf_rdcnt", rd_count, 3);
    cs_high();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
